rx_frame: RTL and testbench
===========================

Name: rx_frame

Overview:
- Byte-level receive framer directly downstream of the bit deserializer.
- Consumes deserialized bytes (data/data_clk), the running CRC and the bus_idle frame delimiter.
- Parses the frame header (src, dst, len), applies the destination filter and writes header plus payload into the RX packet RAM.
- Checks the trailing CRC and reports completion, CRC error, overflow-drop, length error or truncation to the register/control logic.

Parameters:
MAX_LEN, 253, largest accepted payload length. Header (3) + MAX_LEN must be 256 or less.
BCAST_ADDR, 8'hff, destination address always accepted.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
bus_idle  input  1  level; high = bus idle, frame boundary
data  input  8  received byte, valid when data_clk=1
data_clk  input  1  one-cycle strobe per received byte
crc_data  input  16  running CRC over all bits so far; includes current byte when data_clk=1
filter  input  8  own node address
promiscuous  input  1  1 = accept any destination
buf_free  input  1  RX RAM buffer available to receive
ram_wr_en  output  1  RAM write strobe
ram_wr_addr  output  8  RAM byte address
ram_wr_byte  output  8  RAM write data
rx_len  output  8  payload length of the last good frame
rx_done  output  1  pulse: good frame stored
rx_crc_err  output  1  pulse: CRC mismatch
rx_lost  output  1  pulse: frame dropped, buffer not free
rx_err  output  1  pulse: len > MAX_LEN
rx_break  output  1  pulse: bus_idle before frame complete

Behaviour:
- Reset: state IDLE; all outputs 0; byte counter 0.
- All outputs are registered. RAM write and status pulses appear 1 cycle after the causing data_clk.
- FSM states: IDLE, RECV, CRC, DROP.
- bus_idle=1 has top priority over any data_clk in the same cycle:
  - In RECV or CRC with byte counter > 0: pulse rx_break, then go to IDLE.
  - In all other cases: go to IDLE with no status pulse.
- IDLE, on data_clk:
  - If buf_free=0: pulse rx_lost, go to DROP.
  - Otherwise: write byte at addr 0, set cnt=1, go to RECV.
- RECV, on each data_clk: write the byte at addr cnt, then increment cnt.
  - cnt=1 (dst byte): if promiscuous=0 and dst != filter and dst != BCAST_ADDR, go to DROP silently (this byte is still written; no pulse).
  - cnt=2 (len byte): latch len. If len > MAX_LEN, pulse rx_err and go to DROP.
  - When cnt reaches 3+len after the write, go to CRC; crc_cnt=0. len=0 goes to CRC right after the len byte.
- CRC, on data_clk: bytes are not written to RAM.
  - First byte: increment crc_cnt.
  - Second byte, crc_data==16'h0000: set rx_len=len, pulse rx_done, go to DROP.
  - Second byte, crc_data != 16'h0000: pulse rx_crc_err, go to DROP.
- DROP: ignore data_clk; leave only on bus_idle. A new frame always requires an idle gap.
- At most one status pulse per frame. Pulses are exactly 1 cycle.
- ram_wr_addr and ram_wr_byte hold their last value when ram_wr_en=0.
- ram_wr_addr never exceeds 255; guaranteed by the MAX_LEN bound.
- buf_free is sampled only on the first byte. A later deassertion does not affect the current frame.
- rx_len changes only on rx_done.

Test Plan:
- Unicast good frame: filter=0x05, bytes 01 05 02 AA BB + correct CRC, then bus_idle -> writes at addr 0..4, rx_done=1 for 1 cycle, rx_len=2.
- Filtered frame: dst=0x07, filter=0x05, promiscuous=0 -> one write at addr 0 and one at addr 1, then no further writes and no pulses. Broadcast dst=0xff -> rx_done.
- CRC error: same frame as the unicast case with the last CRC byte flipped -> rx_crc_err pulse, no rx_done, rx_len unchanged.
- buf_free=0 at the first byte -> rx_lost pulse, zero RAM writes. The next frame after bus_idle with buf_free=1 is received normally.
- len=254 -> rx_err after the 3rd byte; remaining bytes ignored until bus_idle. len=0 frame -> 3 writes, then rx_done with rx_len=0.
- bus_idle raised after the 4th byte of a len=5 frame -> rx_break pulse, state IDLE. The next frame starts at addr 0. Assert reset_n=0 mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/rx_frame.sv
// Byte-level receive framer: parses src/dst/len, filters on destination, stores
// header and payload into the RX packet RAM and reports the frame outcome.
module rx_frame #(
    parameter int         MAX_LEN    = 253,
    parameter logic [7:0] BCAST_ADDR = 8'hff
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_idle,
    input  logic [7:0]  data,
    input  logic        data_clk,
    input  logic [15:0] crc_data,
    input  logic [7:0]  filter,
    input  logic        promiscuous,
    input  logic        buf_free,
    output logic        ram_wr_en,
    output logic [7:0]  ram_wr_addr,
    output logic [7:0]  ram_wr_byte,
    output logic [7:0]  rx_len,
    output logic        rx_done,
    output logic        rx_crc_err,
    output logic        rx_lost,
    output logic        rx_err,
    output logic        rx_break
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        CRC  = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state, state_d;
    // Nine bits: the count reaches 3+MAX_LEN (up to 256) after the last write.
    logic [8:0]  cnt, cnt_d;
    logic [7:0]  len, len_d;
    logic        crc_cnt, crc_cnt_d;

    logic        wr_en_d;
    logic [7:0]  wr_addr_d, wr_byte_d, rx_len_d;
    logic        done_d, crc_err_d, lost_d, err_d, break_d;
    logic [7:0]  len_eff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            len         <= '0;
            crc_cnt     <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_byte <= '0;
            rx_len      <= '0;
            rx_done     <= 1'b0;
            rx_crc_err  <= 1'b0;
            rx_lost     <= 1'b0;
            rx_err      <= 1'b0;
            rx_break    <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            len         <= len_d;
            crc_cnt     <= crc_cnt_d;
            ram_wr_en   <= wr_en_d;
            ram_wr_addr <= wr_addr_d;
            ram_wr_byte <= wr_byte_d;
            rx_len      <= rx_len_d;
            rx_done     <= done_d;
            rx_crc_err  <= crc_err_d;
            rx_lost     <= lost_d;
            rx_err      <= err_d;
            rx_break    <= break_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        len_d     = len;
        crc_cnt_d = crc_cnt;
        wr_en_d   = 1'b0;
        wr_addr_d = ram_wr_addr;
        wr_byte_d = ram_wr_byte;
        rx_len_d  = rx_len;
        done_d    = 1'b0;
        crc_err_d = 1'b0;
        lost_d    = 1'b0;
        err_d     = 1'b0;
        break_d   = 1'b0;
        // The length byte is used in the same cycle it arrives.
        len_eff   = (cnt == 9'd2) ? data : len;

        if (bus_idle) begin
            if ((state == RECV || state == CRC) && cnt != 9'd0)
                break_d = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (data_clk) begin
            case (state)
                IDLE: begin
                    if (!buf_free) begin
                        lost_d  = 1'b1;
                        state_d = DROP;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = 8'd0;
                        wr_byte_d = data;
                        cnt_d     = 9'd1;
                        state_d   = RECV;
                    end
                end
                RECV: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt[7:0];
                    wr_byte_d = data;
                    cnt_d     = cnt + 9'd1;
                    if (cnt == 9'd1) begin
                        if (!promiscuous && data != filter && data != BCAST_ADDR)
                            state_d = DROP;
                    end else begin
                        if (cnt == 9'd2)
                            len_d = data;
                        if (cnt == 9'd2 && data > 8'(MAX_LEN)) begin
                            err_d   = 1'b1;
                            state_d = DROP;
                        end else if (cnt + 9'd1 == {1'b0, len_eff} + 9'd3) begin
                            state_d   = CRC;
                            crc_cnt_d = 1'b0;
                        end
                    end
                end
                CRC: begin
                    if (!crc_cnt) begin
                        crc_cnt_d = 1'b1;
                    end else if (crc_data == 16'h0000) begin
                        rx_len_d = len;
                        done_d   = 1'b1;
                        state_d  = DROP;
                    end else begin
                        crc_err_d = 1'b1;
                        state_d   = DROP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame.sv
// Directed bench for rx_frame: one task per scenario, inline checks against
// hand-computed RAM writes, status pulses and rx_len.
module tb_rx_frame;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bus_idle = 1'b1;
    logic [7:0]  data = '0;
    logic        data_clk = 1'b0;
    logic [15:0] crc_data = '0;
    logic [7:0]  filter = 8'h05;
    logic        promiscuous = 1'b0;
    logic        buf_free = 1'b1;
    logic        ram_wr_en;
    logic [7:0]  ram_wr_addr, ram_wr_byte, rx_len;
    logic        rx_done, rx_crc_err, rx_lost, rx_err, rx_break;

    int total = 0;
    int bad = 0;

    logic [7:0] wr_addr_log[$];
    logic [7:0] wr_byte_log[$];
    logic [7:0] frame_q[$];
    int done_cnt, crc_err_cnt, lost_cnt, err_cnt, break_cnt;

    rx_frame dut (
        .clk(clk), .reset_n(reset_n), .bus_idle(bus_idle), .data(data),
        .data_clk(data_clk), .crc_data(crc_data), .filter(filter),
        .promiscuous(promiscuous), .buf_free(buf_free),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_byte(ram_wr_byte),
        .rx_len(rx_len), .rx_done(rx_done), .rx_crc_err(rx_crc_err),
        .rx_lost(rx_lost), .rx_err(rx_err), .rx_break(rx_break)
    );

    always #5 clk = ~clk;

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_wr_en) begin
                wr_addr_log.push_back(ram_wr_addr);
                wr_byte_log.push_back(ram_wr_byte);
            end
            if (rx_done)    done_cnt++;
            if (rx_crc_err) crc_err_cnt++;
            if (rx_lost)    lost_cnt++;
            if (rx_err)     err_cnt++;
            if (rx_break)   break_cnt++;
        end
    end

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_byte_log.delete();
        done_cnt = 0; crc_err_cnt = 0; lost_cnt = 0; err_cnt = 0; break_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [15:0] crc);
        @(posedge clk); #1;
        data = b; crc_data = crc; data_clk = 1'b1;
        @(posedge clk); #1;
        data_clk = 1'b0;
    endtask

    task automatic idle_gap();
        @(posedge clk); #1;
        bus_idle = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus_idle = 1'b0;
    endtask

    // Sends frame_q; only the final byte carries last_crc as the running CRC.
    task automatic send_frame(input logic [15:0] last_crc);
        clear_logs();
        bus_idle = 1'b0;
        foreach (frame_q[i])
            send_byte(frame_q[i], (i == frame_q.size() - 1) ? last_crc : 16'hbeef);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({ram_wr_en, ram_wr_addr, ram_wr_byte, rx_len} !== 25'd0) begin
            bad++;
            $display("FAIL reset_data: got %h expected 0", {ram_wr_en, ram_wr_addr, ram_wr_byte, rx_len});
        end
        total++;
        if ({rx_done, rx_crc_err, rx_lost, rx_err, rx_break} !== 5'd0) begin
            bad++;
            $display("FAIL reset_pulses: got %b expected 00000",
                     {rx_done, rx_crc_err, rx_lost, rx_err, rx_break});
        end
    endtask

    task automatic test_unicast();
        logic [7:0] exp_b[5] = '{8'h01, 8'h05, 8'h02, 8'haa, 8'hbb};
        frame_q = '{8'h01, 8'h05, 8'h02, 8'haa, 8'hbb, 8'hc1, 8'hc2};
        send_frame(16'h0000);
        idle_gap();
        check_int("uni_nwr", wr_addr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_addr_log.size(); i++) begin
            total++;
            if (wr_addr_log[i] !== 8'(i) || wr_byte_log[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL uni_wr%0d: got a=%h d=%h expected a=%h d=%h",
                         i, wr_addr_log[i], wr_byte_log[i], 8'(i), exp_b[i]);
            end
        end
        check_int("uni_done", done_cnt, 1);
        check_int("uni_other", crc_err_cnt + lost_cnt + err_cnt + break_cnt, 0);
        check_int("uni_len", rx_len, 2);
    endtask

    task automatic test_filter();
        frame_q = '{8'h01, 8'h07, 8'h02, 8'haa, 8'hbb, 8'hc1, 8'hc2};
        send_frame(16'h0000);
        idle_gap();
        check_int("filt_nwr", wr_addr_log.size(), 2);
        if (wr_addr_log.size() == 2) begin
            total++;
            if (wr_addr_log[1] !== 8'd1 || wr_byte_log[1] !== 8'h07) begin
                bad++;
                $display("FAIL filt_wr1: got a=%h d=%h expected a=01 d=07",
                         wr_addr_log[1], wr_byte_log[1]);
            end
        end
        check_int("filt_pulses", done_cnt + crc_err_cnt + lost_cnt + err_cnt + break_cnt, 0);
        check_int("filt_len", rx_len, 2);
        frame_q = '{8'h01, 8'hff, 8'h03, 8'h11, 8'h22, 8'h33, 8'hc1, 8'hc2};
        send_frame(16'h0000);
        idle_gap();
        check_int("bcast_nwr", wr_addr_log.size(), 6);
        check_int("bcast_done", done_cnt, 1);
        check_int("bcast_len", rx_len, 3);
    endtask

    task automatic test_crc_err();
        frame_q = '{8'h01, 8'h05, 8'h02, 8'haa, 8'hbb, 8'hc1, 8'hc3};
        send_frame(16'h0001);
        idle_gap();
        check_int("crc_err", crc_err_cnt, 1);
        check_int("crc_done", done_cnt, 0);
        check_int("crc_len", rx_len, 3);
    endtask

    task automatic test_lost();
        buf_free = 1'b0;
        frame_q = '{8'h01, 8'h05, 8'h01, 8'h44, 8'hc1, 8'hc2};
        send_frame(16'h0000);
        idle_gap();
        check_int("lost_pulse", lost_cnt, 1);
        check_int("lost_nwr", wr_addr_log.size(), 0);
        check_int("lost_done", done_cnt, 0);
        buf_free = 1'b1;
        // buf_free drops after the first byte: the frame must still complete.
        clear_logs();
        bus_idle = 1'b0;
        send_byte(8'h01, 16'hbeef);
        buf_free = 1'b0;
        send_byte(8'h05, 16'hbeef);
        send_byte(8'h01, 16'hbeef);
        send_byte(8'h44, 16'hbeef);
        send_byte(8'hc1, 16'hbeef);
        send_byte(8'hc2, 16'h0000);
        idle_gap();
        buf_free = 1'b1;
        check_int("after_lost_done", done_cnt, 1);
        check_int("after_lost_len", rx_len, 1);
        check_int("after_lost_nwr", wr_addr_log.size(), 4);
    endtask

    task automatic test_len();
        frame_q = '{8'h01, 8'h05, 8'hfe, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(16'h0000);
        idle_gap();
        check_int("lenerr_pulse", err_cnt, 1);
        check_int("lenerr_nwr", wr_addr_log.size(), 3);
        check_int("lenerr_other", done_cnt + crc_err_cnt + break_cnt, 0);
        frame_q = '{8'h01, 8'h05, 8'h00, 8'hc1, 8'hc2};
        send_frame(16'h0000);
        idle_gap();
        check_int("len0_nwr", wr_addr_log.size(), 3);
        check_int("len0_done", done_cnt, 1);
        check_int("len0_len", rx_len, 0);
    endtask

    task automatic test_break();
        frame_q = '{8'h01, 8'h05, 8'h05, 8'h11};
        send_frame(16'hbeef);
        idle_gap();
        check_int("brk_pulse", break_cnt, 1);
        check_int("brk_nwr", wr_addr_log.size(), 4);
        check_int("brk_done", done_cnt, 0);
        frame_q = '{8'h09, 8'h05, 8'h01, 8'h77, 8'hc1, 8'hc2};
        send_frame(16'h0000);
        idle_gap();
        total++;
        if (wr_addr_log.size() == 0 || wr_addr_log[0] !== 8'd0 || wr_byte_log[0] !== 8'h09) begin
            bad++;
            $display("FAIL brk_restart: first write missing or wrong, n=%0d expected a=00 d=09",
                     wr_addr_log.size());
        end
        check_int("brk_next_done", done_cnt, 1);
        check_int("brk_next_len", rx_len, 1);
    endtask

    task automatic test_reset_mid();
        bus_idle = 1'b0;
        @(posedge clk); #1;
        data = 8'h01; data_clk = 1'b1;
        @(posedge clk); #1;
        data = 8'h05;
        @(posedge clk); #1;
        data_clk = 1'b0;
        check_int("mid_wr_en", ram_wr_en, 1);
        check_int("mid_addr", ram_wr_addr, 1);
        #1 reset_n = 1'b0;
        #1;
        check_int("rst_wr_en", ram_wr_en, 0);
        check_int("rst_addr", ram_wr_addr, 0);
        check_int("rst_byte", ram_wr_byte, 0);
        check_int("rst_len", rx_len, 0);
        #10 reset_n = 1'b1;
        idle_gap();
    endtask

    initial begin
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        idle_gap();
        test_unicast();
        test_filter();
        test_crc_err();
        test_lost();
        test_len();
        test_break();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
